// File: rtl/icache_refill.sv
// Instruction-cache miss handler: sweeps the tag store invalid after reset,
// then on each fetch miss stalls the front end, reads the whole line from
// memory word by word, writes it into the data array and finally validates
// the tag so fetch can retry and hit.
module icache_refill #(
  parameter int LINE_WORDS = 2,
  parameter int INDEX_W    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          miss,
  input  logic [31:0]                   miss_addr,
  output logic                          stall,
  output logic                          mem_req,
  output logic [31:0]                   mem_addr,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata,
  output logic                          cache_we,
  output logic [INDEX_W-1:0]            cache_index,
  output logic [$clog2(LINE_WORDS)-1:0] cache_word,
  output logic [31:0]                   cache_wdata,
  output logic                          tag_we,
  output logic                          tag_valid,
  output logic [32-INDEX_W-$clog2(LINE_WORDS)-3:0] tag_wdata
);

  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int OFF_W   = WORD_W + 2;
  localparam int TAG_W   = 32 - INDEX_W - OFF_W;
  localparam int LADDR_W = 32 - OFF_W;

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_TAG  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic [WORD_W-1:0]  word_cnt;
  logic [INDEX_W-1:0] init_cnt;
  // Line address of the miss; index and tag are its low and high fields.
  logic [LADDR_W-1:0] line_addr;
  // Byte-offset bits of the miss PC play no part in a line refill.
  logic               unused_offset;

  assign unused_offset = ^miss_addr[OFF_W-1:0];

  // Control FSM with the invalidation sweep and word counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      word_cnt <= '0;
      init_cnt <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + INDEX_W'(1);
          if (&init_cnt) state <= S_IDLE;
        end
        S_IDLE: begin
          if (miss) begin
            word_cnt <= '0;
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            word_cnt <= word_cnt + WORD_W'(1);
            if (&word_cnt) state <= S_TAG;
          end
        end
        S_TAG:   state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end

  // Capture the missing line address; later miss_addr changes are ignored.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && miss) line_addr <= miss_addr[31:OFF_W];
  end

  // Output decode; reset forces every output low in the same cycle.
  always_comb begin
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    cache_we    = 1'b0;
    cache_index = '0;
    cache_word  = '0;
    cache_wdata = '0;
    tag_we      = 1'b0;
    tag_valid   = 1'b0;
    tag_wdata   = '0;
    if (!reset) begin
      case (state)
        S_INIT: begin
          stall       = 1'b1;
          tag_we      = 1'b1;
          cache_index = init_cnt;
        end
        S_IDLE: stall = miss;
        S_FILL: begin
          stall       = 1'b1;
          mem_req     = 1'b1;
          mem_addr    = {line_addr, word_cnt, 2'b00};
          cache_index = line_addr[INDEX_W-1:0];
          if (mem_ack) begin
            cache_we    = 1'b1;
            cache_word  = word_cnt;
            cache_wdata = mem_rdata;
          end
        end
        S_TAG: begin
          stall       = 1'b1;
          tag_we      = 1'b1;
          tag_valid   = 1'b1;
          tag_wdata   = line_addr[LADDR_W-1:INDEX_W];
          cache_index = line_addr[INDEX_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: directed and random misses against a line-level
// memory model, with a scoreboard of expected data/tag array writes.
module tb_icache_refill;

  localparam int LINE_WORDS = 2;
  localparam int INDEX_W    = 1;
  localparam int NUM_LINES  = 1 << INDEX_W;
  localparam int WORD_W     = $clog2(LINE_WORDS);
  localparam int OFF_W      = WORD_W + 2;
  localparam int TAG_W      = 32 - INDEX_W - OFF_W;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                miss = 1'b0;
  logic [31:0]         miss_addr = '0;
  logic                stall, mem_req, mem_ack;
  logic [31:0]         mem_addr, mem_rdata;
  logic                cache_we;
  logic [INDEX_W-1:0]  cache_index;
  logic [WORD_W-1:0]   cache_word;
  logic [31:0]         cache_wdata;
  logic                tag_we, tag_valid;
  logic [TAG_W-1:0]    tag_wdata;

  logic                resp_ack = 1'b0;
  logic [31:0]         resp_data = '0;
  logic                spur_ack = 1'b0;
  logic [31:0]         spur_data = '0;
  int                  cur_delay = 0;

  assign mem_ack   = resp_ack | spur_ack;
  assign mem_rdata = resp_ack ? resp_data : spur_data;

  typedef struct {
    bit                 is_tag;
    logic [INDEX_W-1:0] index;
    logic [WORD_W-1:0]  word;
    logic [31:0]        data;
    logic [31:0]        addr;
    bit                 valid;
    logic [TAG_W-1:0]   tag;
  } ev_t;

  ev_t         sb[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;

  icache_refill #(.LINE_WORDS(LINE_WORDS), .INDEX_W(INDEX_W)) dut (
    .clk(clk), .reset(reset), .miss(miss), .miss_addr(miss_addr),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cache_we(cache_we), .cache_index(cache_index), .cache_word(cache_word),
    .cache_wdata(cache_wdata), .tag_we(tag_we), .tag_valid(tag_valid),
    .tag_wdata(tag_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Memory: acknowledges a pending request after cur_delay waiting cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !reset) begin
        if (wcnt >= cur_delay) begin
          resp_ack  = 1'b1;
          resp_data = mem.exists(mem_addr) ? mem[mem_addr] : $urandom;
          wcnt = 0;
        end else begin
          resp_ack = 1'b0;
          wcnt++;
        end
      end else begin
        resp_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: every array write must match the head of the scoreboard,
  // and an outstanding request must hold steady until acknowledged.
  initial begin
    ev_t         e;
    bit          ok;
    bit          hold_pending;
    logic [31:0] held_addr;
    hold_pending = 1'b0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      if (cache_we || tag_we) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cache_we=%0b tag_we=%0b tag_valid=%0b index=%0d required none",
                   cache_we, tag_we, tag_valid, cache_index);
        end else begin
          e = sb.pop_front();
          if (e.is_tag)
            ok = tag_we && !cache_we && tag_valid == e.valid &&
                 tag_wdata == e.tag && cache_index == e.index;
          else
            ok = cache_we && !tag_we && cache_word == e.word &&
                 cache_wdata == e.data && cache_index == e.index && mem_addr == e.addr;
          if (!ok) begin
            errors++;
            $display("FAIL array_write got we=%0b twe=%0b idx=%0d word=%0d data=%h addr=%h valid=%0b tag=%h required is_tag=%0b idx=%0d word=%0d data=%h addr=%h valid=%0b tag=%h",
                     cache_we, tag_we, cache_index, cache_word, cache_wdata, mem_addr, tag_valid, tag_wdata,
                     e.is_tag, e.index, e.word, e.data, e.addr, e.valid, e.tag);
          end
        end
      end
      if (hold_pending) begin
        checks++;
        if (!(reset || (mem_req && mem_addr == held_addr))) begin
          errors++;
          $display("FAIL req_hold got mem_req=%0b mem_addr=%h required mem_req=1 mem_addr=%h",
                   mem_req, mem_addr, held_addr);
        end
      end
      hold_pending = mem_req && !mem_ack && !reset;
      held_addr    = mem_addr;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  // Applies reset for ncycles, then expects the invalidation sweep.
  task automatic do_reset(input int ncycles);
    ev_t e;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    for (int i = 0; i < NUM_LINES; i++) begin
      e = '{is_tag: 1'b1, index: INDEX_W'(i), word: '0, data: '0, addr: '0, valid: 1'b0, tag: '0};
      sb.push_back(e);
    end
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      check("reset_outputs_zero",
            64'({stall, mem_req, mem_addr, cache_we, cache_index, cache_word,
                 cache_wdata, tag_we, tag_valid, tag_wdata} != '0), 64'(0));
      if (c < ncycles - 1) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      @(negedge clk);
      check("init_stall", 64'(stall), 64'(1));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("idle_stall_low", 64'(stall), 64'(0));
    check("idle_strobes_low", 64'({cache_we, tag_we, mem_req}), 64'(0));
    check("init_sweep_done", 64'(sb.size()), 64'(0));
  endtask

  // Expected writes for one line refill, in fill order then the tag.
  task automatic push_line(input logic [31:0] addr, input bit fixed, input int nwords);
    ev_t         e;
    logic [31:0] la;
    la = addr & ~32'(LINE_WORDS * 4 - 1);
    for (int w = 0; w < LINE_WORDS; w++) begin
      mem[la + 32'(4 * w)] = fixed ? 32'hAAAA0001 + 32'(w) : $urandom;
      if (w < nwords) begin
        e = '{is_tag: 1'b0, index: INDEX_W'(addr >> OFF_W), word: WORD_W'(w),
              data: mem[la + 32'(4 * w)], addr: la + 32'(4 * w), valid: 1'b0, tag: '0};
        sb.push_back(e);
      end
    end
    if (nwords == LINE_WORDS) begin
      e = '{is_tag: 1'b1, index: INDEX_W'(addr >> OFF_W), word: '0, data: '0, addr: '0,
            valid: 1'b1, tag: TAG_W'(addr >> (OFF_W + INDEX_W))};
      sb.push_back(e);
    end
  endtask

  // One complete miss; optionally raises miss again during the release cycle.
  task automatic do_miss(input logic [31:0] addr, input int delay, input bit miss_in_done, input bit fixed);
    int k;
    cur_delay = delay;
    push_line(addr, fixed, LINE_WORDS);
    @(posedge clk); #1;
    miss = 1'b1;
    miss_addr = addr;
    @(negedge clk);
    check("stall_in_miss_cycle", 64'(stall), 64'(1));
    @(posedge clk); #1;
    miss = 1'b0;
    miss_addr = $urandom;
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      k = c;
      if (!stall) break;
    end
    check("release_latency", 64'(k), 64'(LINE_WORDS + 2 + LINE_WORDS * delay));
    check("line_written", 64'(sb.size()), 64'(0));
    if (miss_in_done) begin
      miss = 1'b1;
      miss_addr = $urandom;
      @(posedge clk); #1;
      miss = 1'b0;
      @(negedge clk);
      check("done_miss_ignored", 64'({stall, mem_req}), 64'(0));
    end
  endtask

  task automatic spurious_ack();
    @(posedge clk); #1;
    spur_ack = 1'b1;
    spur_data = $urandom;
    @(negedge clk);
    check("spurious_ack_ignored", 64'({stall, mem_req}), 64'(0));
    @(posedge clk); #1;
    spur_ack = 1'b0;
  endtask

  initial begin
    do_reset(2);
    do_miss(32'h0000_1008, 0, 1'b0, 1'b1);
    do_miss(32'h0000_1008, 3, 1'b0, 1'b1);
    spurious_ack();
    do_miss(32'h0000_2004, 1, 1'b1, 1'b0);
    spurious_ack();
    // Reset the cycle after the first word is acknowledged.
    cur_delay = 0;
    push_line(32'h0000_3000, 1'b0, 1);
    @(posedge clk); #1;
    miss = 1'b1;
    miss_addr = 32'h0000_3000;
    @(posedge clk); #1;
    miss = 1'b0;
    do_reset(1);
    do_miss(32'h0000_0000, 0, 1'b0, 1'b0);
    do_miss(32'h0000_0010, 0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      do_miss($urandom, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 2) == 0) spurious_ack();
    end
    check("scoreboard_empty_at_end", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
